// File: rtl/max_slice_seq.sv
// max_slice_seq: time-shared 2-bit compare/select slice that scans a captured
// operand pair MSB slice first and returns the larger operand and select flag.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | in_ready high, waiting for an operand pair
//   SCAN  | one 2-bit slice compared per cycle, idx counts down to 0
//   DONE  | result held on max_out/a_ge_b until out_ready
module max_slice_seq #(
   parameter int WIDTH      = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] max_out,
   output logic             a_ge_b,
   output logic             busy
);

   localparam int S  = WIDTH / 2;
   localparam int IW = (S > 1) ? $clog2(S) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(S - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] a_q, b_q;
   logic [IW-1:0]    idx;
   logic             decided;
   logic             sel;

   logic [WIDTH-1:0] a_sh, b_sh;
   logic [1:0]       sa, sb;
   logic             dec_now;
   logic             sel_now;
   logic             last;
   logic             exit_scan;

   // current slice of the captured operands and the running decision
   always_comb begin
      a_sh      = a_q >> {idx, 1'b0};
      b_sh      = b_q >> {idx, 1'b0};
      sa        = a_sh[1:0];
      sb        = b_sh[1:0];
      dec_now   = decided | (sa != sb);
      // before any decision an equal slice leans to A, so A==B selects A
      sel_now   = decided ? sel : (sa >= sb);
      last      = (idx == '0);
      exit_scan = EARLY_EXIT ? (dec_now | last) : last;
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = SCAN;
         SCAN:    if (exit_scan) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // operand capture, slice walk and result registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         idx     <= '0;
         decided <= 1'b0;
         sel     <= 1'b0;
         max_out <= '0;
         a_ge_b  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  idx     <= IDX_TOP;
                  decided <= 1'b0;
                  sel     <= 1'b1;
               end
            end
            SCAN: begin
               decided <= dec_now;
               sel     <= sel_now;
               if (exit_scan) begin
                  max_out <= sel_now ? a_q : b_q;
                  a_ge_b  <= sel_now;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_max_slice_seq.sv
// tb_max_slice_seq: drives one early-exit and one full-scan instance with
// shared stimulus; table vectors, random pairs and handshake corner sequences.
module tb_max_slice_seq;

   localparam int W = 8;
   localparam int S = W / 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         out_ready;
   logic [W-1:0] a, b;

   logic         in_ready1, out_valid1, a_ge_b1, busy1;
   logic [W-1:0] max_out1;
   logic         in_ready0, out_valid0, a_ge_b0, busy0;
   logic [W-1:0] max_out0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   max_slice_seq #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
      .max_out(max_out1), .a_ge_b(a_ge_b1), .busy(busy1)
   );

   max_slice_seq #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
      .max_out(max_out0), .a_ge_b(a_ge_b0), .busy(busy0)
   );

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      int           lat1;
      int           lat0;
      logic [W-1:0] vmax;
      logic         vge;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // slice k (1 = MSB slice) holding the most significant differing bit
   function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y, input bit ee);
      logic [W-1:0] d;
      int p;
      d = x ^ y;
      if (!ee || d == '0) return S;
      p = 0;
      for (int i = 0; i < W; i++) if (d[i]) p = i;
      return S - p / 2;
   endfunction

   task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input int el1, input int el0,
                          input logic [W-1:0] em, input logic eg, input string nm);
      int lat1, lat0;
      logic [W-1:0] m1, m0;
      logic g1, g0;
      lat1 = 0; lat0 = 0; m1 = '0; m0 = '0; g1 = 1'b0; g0 = 1'b0;
      check({nm, " idle1"}, {31'd0, in_ready1}, 32'd1);
      check({nm, " idle0"}, {31'd0, in_ready0}, 32'd1);
      in_valid  = 1'b1;
      a         = ta;
      b         = tbv;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      for (int c = 1; c <= S + 2; c++) begin
         @(negedge clk);
         if (out_valid1 && lat1 == 0) begin
            lat1 = c; m1 = max_out1; g1 = a_ge_b1;
         end else if (lat1 != 0 && c == lat1 + 1) begin
            check({nm, " rdy_after1"}, {30'd0, in_ready1, out_valid1}, 32'd2);
         end
         if (out_valid0 && lat0 == 0) begin
            lat0 = c; m0 = max_out0; g0 = a_ge_b0;
         end else if (lat0 != 0 && c == lat0 + 1) begin
            check({nm, " rdy_after0"}, {30'd0, in_ready0, out_valid0}, 32'd2);
         end
      end
      check({nm, " lat_ee1"}, lat1, el1);
      check({nm, " lat_ee0"}, lat0, el0);
      check({nm, " max_ee1"}, {24'd0, m1}, {24'd0, em});
      check({nm, " max_ee0"}, {24'd0, m0}, {24'd0, em});
      check({nm, " ge_ee1"}, {31'd0, g1}, {31'd0, eg});
      check({nm, " ge_ee0"}, {31'd0, g0}, {31'd0, eg});
   endtask

   initial begin
      vecs[0] = '{8'hC3, 8'h3C, 1, 4, 8'hC3, 1'b1};
      vecs[1] = '{8'h12, 8'h13, 4, 4, 8'h13, 1'b0};
      vecs[2] = '{8'h5A, 8'h5A, 4, 4, 8'h5A, 1'b1};
      vecs[3] = '{8'hF0, 8'h0F, 1, 4, 8'hF0, 1'b1};
      vecs[4] = '{8'h80, 8'h7F, 1, 4, 8'h80, 1'b1};
      vecs[5] = '{8'h00, 8'h00, 4, 4, 8'h00, 1'b1};
      vecs[6] = '{8'h24, 8'h28, 3, 4, 8'h28, 1'b0};
      vecs[7] = '{8'h01, 8'h02, 4, 4, 8'h02, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst in_ready", {30'd0, in_ready1, in_ready0}, 32'd3);
      check("rst out_valid", {30'd0, out_valid1, out_valid0}, 32'd0);
      check("rst busy", {30'd0, busy1, busy0}, 32'd0);
      check("rst max_out", {16'd0, max_out1, max_out0}, 32'd0);
      check("rst a_ge_b", {30'd0, a_ge_b1, a_ge_b0}, 32'd0);

      for (int i = 0; i < 8; i++)
         run_txn(vecs[i].va, vecs[i].vb, vecs[i].lat1, vecs[i].lat0,
                 vecs[i].vmax, vecs[i].vge, $sformatf("vec%0d", i));

      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
            default: rb = W'($urandom);
         endcase
         run_txn(ra, rb, ref_lat(ra, rb, 1'b1), ref_lat(ra, rb, 1'b0),
                 (ra >= rb) ? ra : rb, ra >= rb, $sformatf("rnd%0d", i));
      end

      // backpressure with a competing pair presented while busy
      in_valid = 1'b1; a = 8'hF0; b = 8'h0F; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      a = 8'h00; b = 8'hFF;
      for (int c = 1; c <= S + 3; c++) begin
         @(negedge clk);
         check($sformatf("bp in_ready c%0d", c), {30'd0, in_ready1, in_ready0}, 32'd0);
         check($sformatf("bp busy c%0d", c), {30'd0, busy1, busy0}, 32'd3);
         if (c >= S) begin
            check($sformatf("bp out_valid c%0d", c), {30'd0, out_valid1, out_valid0}, 32'd3);
            check($sformatf("bp max c%0d", c), {16'd0, max_out1, max_out0}, 32'hF0F0);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp handoff out_valid", {30'd0, out_valid1, out_valid0}, 32'd0);
      check("bp handoff in_ready", {30'd0, in_ready1, in_ready0}, 32'd3);
      in_valid = 1'b0;
      @(negedge clk);
      check("bp no capture busy", {30'd0, busy1, busy0}, 32'd0);
      check("bp no capture max", {16'd0, max_out1, max_out0}, 32'hF0F0);
      check("bp no capture ge", {30'd0, a_ge_b1, a_ge_b0}, 32'd3);

      // reset during SCAN discards the pair
      in_valid = 1'b1; a = 8'h12; b = 8'h13;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("mid scan busy", {30'd0, busy1, busy0}, 32'd3);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid rst in_ready", {30'd0, in_ready1, in_ready0}, 32'd3);
      check("mid rst out_valid", {30'd0, out_valid1, out_valid0}, 32'd0);
      check("mid rst max_out", {16'd0, max_out1, max_out0}, 32'd0);
      check("mid rst busy", {30'd0, busy1, busy0}, 32'd0);
      repeat (S + 2) @(negedge clk);
      check("mid rst stays idle", {28'd0, out_valid1, out_valid0, busy1, busy0}, 32'd0);
      run_txn(8'h01, 8'h02, 4, 4, 8'h02, 1'b0, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/max_slice_seq.md
# max_slice_seq

Sequential controller for the 2-bit compare/select slice used in the max datapath partitions. It accepts one pair of WIDTH-bit operands over a valid/ready handshake and walks the slice across the operands, most-significant slice first. It optionally stops as soon as a slice decides the result. It then presents the larger operand and the select flag on an output handshake, replacing a WIDTH-wide combinational max tree with one time-shared slice.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥ 2; slice count S = WIDTH/2.
- EARLY_EXIT, 1, 1 = finish at the first deciding slice; 0 = always evaluate all S slices.
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- max_out  out  WIDTH  larger of captured A and B.
- a_ge_b  out  1  1 if A ≥ B (A selected), 0 if B selected.
- busy  out  1  high in SCAN or DONE.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready=1. If in_valid, capture a and b into internal registers. Set slice index idx=S-1, decided=0, go to SCAN. The a and b inputs are ignored after capture.
- SCAN: each cycle, evaluate slice idx, which is bits [2·idx+1 : 2·idx] of the captured A and B, as an unsigned 2-bit compare.
  - Slice A > slice B: decided=1, sel=A.
  - Slice A < slice B: decided=1, sel=B.
  - Equal: no decision from this slice.
  - Once decided=1, later slices cannot change sel.
- SCAN exit:
  - EARLY_EXIT=1: exit at the first deciding slice, or when idx=0.
  - EARLY_EXIT=0: exit only when idx=0.
  - On exit: if no slice decided (A==B), sel=A. Register max_out = sel ? A : B and a_ge_b = sel. Set out_valid=1, go to DONE.
  - Otherwise: idx decrements.
- DONE: hold out_valid, max_out and a_ge_b stable. When out_valid & out_ready, clear out_valid and go to IDLE. No new pair is accepted in the handoff cycle.
- in_ready=0 in SCAN and DONE. busy = (state != IDLE).
- Reset, including mid-SCAN or mid-DONE: state=IDLE and the in-flight pair is discarded.
- Width rules: idx is ceil(log2(S)) bits, minimum 1. All comparisons are unsigned.

## Timing
- Reset values: in_ready=1 on the first cycle after reset; out_valid=0, max_out=0, a_ge_b=0, busy=0.
- Accept happens at rising edge E0, when in_valid & in_ready.
- Latency, EARLY_EXIT=1, deciding slice k (k=1 is the MSB slice): out_valid is high after edge E0+k. If A==B, out_valid is high after E0+S.
- Latency, EARLY_EXIT=0: out_valid is always high after E0+S.
- out_valid drops after the edge where out_ready=1. in_ready rises at that same edge.
- Next accept: earliest one edge after in_ready rises.
- Throughput: at best one pair per k+2 cycles.
- out_ready may be held high in advance. It is only sampled in DONE.

## Test plan
- WIDTH=8, EARLY_EXIT=1, a=0xC3, b=0x3C, out_ready=1 → out_valid one cycle after accept; max_out=0xC3, a_ge_b=1; in_ready back high the following cycle.
- WIDTH=8, EARLY_EXIT=1, a=0x12, b=0x13 → decided at slice 4; out_valid 4 cycles after accept; max_out=0x13, a_ge_b=0.
- WIDTH=8, a=b=0x5A, both EARLY_EXIT values → out_valid 4 cycles after accept; max_out=0x5A, a_ge_b=1.
- WIDTH=8, EARLY_EXIT=0, a=0xC3, b=0x3C → out_valid 4 cycles after accept, not 1; max_out=0xC3.
- Backpressure and input hold, WIDTH=8, EARLY_EXIT=1, a=0xF0, b=0x0F:
  - Hold out_ready=0 for 3 cycles in DONE → max_out=0xF0 and out_valid stay stable; in_ready=0 and busy=1 throughout.
  - Drive in_valid=1 with a=0x00, b=0xFF during SCAN/DONE → no new pair is captured.
  - Release out_ready → handoff completes in one cycle.
- Reset mid-operation: rst_n=0 for one edge during SCAN with a=0x12, b=0x13 → next cycle IDLE, out_valid=0, max_out=0, in_ready=1; a new pair a=0x01, b=0x02 then completes normally with max_out=0x02.
